// File: rtl/mult_div_unit_pkg.sv
// Shared types and constants for the MIPS multiply/divide unit.
// Optional feature macro: MDU_FAST_MUL_EN (single-cycle multiply).
package mult_div_unit_pkg;

  typedef logic        i1;
  typedef logic [31:0] i32;
  typedef logic [63:0] i64;

  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  localparam i32 MDU_DIV0_QUOT = 32'hFFFF_FFFF;

  function automatic i32 abs32(input i32 v);
    return v[31] ? -v : v;
  endfunction

endpackage

// File: rtl/mult_div_unit_divider.sv
// Unsigned radix-2 core: restoring divide, or shift-add multiply when mul_mode is set.
// The 64-bit acc holds {remainder, quotient} for divide and {product_hi, product_lo} for multiply.
module mdu_divider
  import mult_div_unit_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic load,
  input  logic step,
  input  logic mul_mode,
  input  i64   load_acc,
  input  i32   load_operand,
  output i64   acc
);

  i32          operand;
  i64          acc_q;
  logic [32:0] shifted_hi;
  logic [32:0] trial;
  logic [32:0] mul_sum;

  // shifted_hi is the upper 33 bits of acc<<1; a negative trial means the divisor did not fit
  always_comb begin
    shifted_hi = acc_q[63:31];
    trial      = shifted_hi - {1'b0, operand};
    mul_sum    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, operand} : 33'd0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q   <= '0;
      operand <= '0;
    end else if (load) begin
      acc_q   <= load_acc;
      operand <= load_operand;
    end else if (step) begin
      if (mul_mode)
        acc_q <= {mul_sum, acc_q[31:1]};
      else if (!trial[32])
        acc_q <= {trial[31:0], acc_q[30:0], 1'b1};
      else
        acc_q <= {shifted_hi[31:0], acc_q[30:0], 1'b0};
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit producing a one-cycle HI/LO write pulse.
// Define MDU_FAST_MUL_EN to compute multiplies in one cycle with a synthesized multiplier.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic    clk,
  input  logic    resetn,
  input  logic    start,
  input  mdu_op_t op,
  input  i32      a,
  input  i32      b,
  input  logic    flush,
  output logic    busy,
  output logic    done,
  output logic    hi_write,
  output logic    lo_write,
  output i32      hi_data,
  output i32      lo_data
);

  mdu_state_t state, next_state;
  logic [4:0] counter;
  mdu_op_t    op_q;
  i1          a_neg, b_neg, div0;
  i32         hi_hold, lo_hold;
  i1          load, step, signed_op, fast_mul;
  i64         load_acc, acc, prod;
  i32         quot, rem;

  assign signed_op = (op == MULT) || (op == DIV);

`ifdef MDU_FAST_MUL_EN
  logic signed [63:0] sa, sb;
  assign fast_mul = !op[1];
  assign sa       = {{32{a[31]}}, a};
  assign sb       = {{32{b[31]}}, b};
  assign load_acc = !op[1] ? ((op == MULT) ? i64'(sa * sb) : ({32'b0, a} * {32'b0, b}))
                           : {32'b0, signed_op ? abs32(a) : a};
`else
  assign fast_mul = 1'b0;
  assign load_acc = {32'b0, signed_op ? abs32(a) : a};
`endif

  mdu_divider u_core (
    .clk          (clk),
    .resetn       (resetn),
    .load         (load),
    .step         (step),
    .mul_mode     (!op_q[1]),
    .load_acc     (load_acc),
    .load_operand (signed_op ? abs32(b) : b),
    .acc          (acc)
  );

  // flush overrides every transition; a fast multiply skips CALC entirely
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    unique case (state)
      IDLE: if (start && !flush) begin
        load       = 1'b1;
        next_state = fast_mul ? DONE : CALC;
      end
      CALC: begin
        step = !flush;
        if (flush)             next_state = IDLE;
        else if (counter == 0) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      counter <= '0;
      op_q    <= MULT;
      a_neg   <= 1'b0;
      b_neg   <= 1'b0;
      div0    <= 1'b0;
      hi_hold <= '0;
      lo_hold <= '0;
    end else begin
      state <= next_state;
      if (load) begin
        counter <= 5'(DIV_ITERS - 1);
        op_q    <= op;
        a_neg   <= signed_op && a[31] && !fast_mul;
        b_neg   <= signed_op && b[31] && !fast_mul;
        div0    <= op[1] && (b == '0);
      end else if (state == CALC && counter != 0) begin
        counter <= counter - 5'd1;
      end
      if (done) begin
        hi_hold <= hi_data;
        lo_hold <= lo_data;
      end
    end
  end

  // Sign fixup from magnitudes; divide by zero forces an all-ones quotient, remainder becomes a
  always_comb begin
    prod = (a_neg ^ b_neg) ? -acc : acc;
    quot = div0 ? MDU_DIV0_QUOT : ((a_neg ^ b_neg) ? -acc[31:0] : acc[31:0]);
    rem  = a_neg ? -acc[63:32] : acc[63:32];
    busy = (state != IDLE);
    done = (state == DONE) && !flush;
    if (state == DONE) begin
      hi_data = op_q[1] ? rem  : prod[63:32];
      lo_data = op_q[1] ? quot : prod[31:0];
    end else begin
      hi_data = hi_hold;
      lo_data = lo_hold;
    end
  end

  assign hi_write = done;
  assign lo_write = done;

endmodule
